// File: rtl/fft8_unpacker.sv
// Output-side buffer for the 8-point parallel FFT: captures whole result vectors into a
// two-slot ping-pong store and streams them one bin per cycle over valid/ready.
module fft8_unpacker #(
  parameter int FFT_DATA_WD = 10,
  parameter int DROP_CNT_WD = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vld_in,
  input  logic [8*FFT_DATA_WD-1:0] din_re,
  input  logic [8*FFT_DATA_WD-1:0] din_im,
  input  logic                     brev,
  output logic                     rdy_in,
  output logic                     vld_out,
  input  logic                     rdy_out,
  output logic [FFT_DATA_WD-1:0]   dout_re,
  output logic [FFT_DATA_WD-1:0]   dout_im,
  output logic [2:0]               dout_idx,
  output logic                     dout_last,
  output logic                     ovf,
  output logic [DROP_CNT_WD-1:0]   drop_cnt
);

  localparam int LW = 8 * FFT_DATA_WD;

  logic [LW-1:0]          r_slot_re [2];
  logic [LW-1:0]          r_slot_im [2];
  logic [1:0]             r_slot_brev;
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic [1:0]             r_cnt;
  logic [2:0]             r_beat;
  logic [DROP_CNT_WD-1:0] r_drop_cnt;

  logic       w_pop;
  logic       w_pop_last;
  logic       w_accept;
  logic       w_drop;
  logic [2:0] w_idx;

  // The core cannot stall, so a frame arriving while both slots are full is
  // still taken if the slot being read finishes in that same cycle.
  always_comb begin
    vld_out    = (r_cnt != 2'd0);
    rdy_in     = (r_cnt != 2'd2);
    w_pop      = vld_out && rdy_out;
    w_pop_last = w_pop && (r_beat == 3'd7);
    w_accept   = vld_in && (rdy_in || w_pop_last);
    w_drop     = vld_in && !w_accept;
    ovf        = w_drop;
    drop_cnt   = r_drop_cnt;
  end

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_idx     = r_slot_brev[r_rd_ptr] ? {r_beat[0], r_beat[1], r_beat[2]} : r_beat;
    dout_re   = '0;
    dout_im   = '0;
    dout_idx  = '0;
    dout_last = 1'b0;
    if (vld_out) begin
      dout_re   = r_slot_re[r_rd_ptr][int'(w_idx)*FFT_DATA_WD +: FFT_DATA_WD];
      dout_im   = r_slot_im[r_rd_ptr][int'(w_idx)*FFT_DATA_WD +: FFT_DATA_WD];
      dout_idx  = w_idx;
      dout_last = (r_beat == 3'd7);
    end
  end

  // NOTE: slot storage is reset too, so a reset leaves no stale frame data visible anywhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        r_slot_re[s] <= '0;
        r_slot_im[s] <= '0;
      end
      r_slot_brev <= '0;
      r_wr_ptr    <= 1'b0;
    end else if (w_accept) begin
      r_slot_re[r_wr_ptr]   <= din_re;
      r_slot_im[r_wr_ptr]   <= din_im;
      r_slot_brev[r_wr_ptr] <= brev;
      r_wr_ptr              <= ~r_wr_ptr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= 1'b0;
      r_beat   <= 3'd0;
    end else if (w_pop) begin
      r_beat <= r_beat + 3'd1;
      if (r_beat == 3'd7) r_rd_ptr <= ~r_rd_ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 2'd0;
    end else begin
      case ({w_accept, w_pop_last})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

endmodule

// File: doc/fft8_unpacker.md
# fft8_unpacker

Output-side companion to the 8-point parallel FFT core. It captures each 8-lane result vector when the core's `vld_out` pulses and buffers it in a two-slot ping-pong store. It then streams the bins one per cycle to a downstream consumer over a valid/ready handshake, in natural or bit-reversed order. It absorbs the core's lack of backpressure and flags frames that arrive with no free slot.

## Interface
- `FFT_DATA_WD`, default 10: width of each real and imaginary component (two's complement).
- `DROP_CNT_WD`, default 8: width of the saturating dropped-frame counter.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `vld_in` in 1: one-cycle frame strobe from the FFT core.
- `din_re` in 8*FFT_DATA_WD: real part of the bins. Lane k is bits [k*W +: W] and holds bin X[k] in natural order.
- `din_im` in 8*FFT_DATA_WD: imaginary part of the bins, same lane layout as `din_re`.
- `brev` in 1: read order for the frame. 0 = natural, 1 = bit-reversed. Sampled with `vld_in`.
- `rdy_in` out 1: at least one slot is free (`cnt != 2`).
- `vld_out` out 1: `dout_*` holds a valid bin.
- `rdy_out` in 1: downstream accepts the bin.
- `dout_re` out FFT_DATA_WD: real part of the current bin.
- `dout_im` out FFT_DATA_WD: imaginary part of the current bin.
- `dout_idx` out 3: frequency index k of the current bin.
- `dout_last` out 1: current bin is the 8th beat of its frame.
- `ovf` out 1: one-cycle pulse when a frame is dropped.
- `drop_cnt` out DROP_CNT_WD: number of dropped frames, saturating.

## Operation
- State:
  - Two slots, each holding 8 × (re, im) plus a stored `brev` bit.
  - 1-bit `wr_ptr`, 1-bit `rd_ptr`.
  - 2-bit `cnt` (0..2).
  - 3-bit beat counter `beat`.
- Accept condition: `vld_in && (cnt < 2 || pop_last)`, where `pop_last = vld_out && rdy_out && beat == 7`.
- On accept:
  - Write `din_re`, `din_im` and `brev` into slot `wr_ptr`.
  - Toggle `wr_ptr`.
- Drop: `vld_in` while the accept condition is false.
  - Slot contents are unchanged.
  - `ovf` pulses for one cycle.
  - `drop_cnt` increments and holds at all-ones.
- Read side:
  - `vld_out = (cnt != 0)`.
  - Current slot is `rd_ptr`.
  - `dout_idx = beat` when the slot's brev is 0; `dout_idx = bitrev3(beat)` when it is 1.
  - `dout_re`/`dout_im` = slot[rd_ptr] lane `dout_idx`.
  - `dout_last = vld_out && beat == 7`.
- Pop on `vld_out && rdy_out`:
  - `beat` increments, wrapping 7→0.
  - On the wrap, toggle `rd_ptr`.
- `cnt` update:
  - Increments on accept without `pop_last`.
  - Decrements on `pop_last` without accept.
  - Unchanged when both occur or neither occurs.
- Idle outputs: when `vld_out = 0`, `dout_re`, `dout_im`, `dout_idx` and `dout_last` are driven to 0.
- Output stability: while `vld_out && !rdy_out`, all `dout_*` hold stable.
- Arithmetic: none. Data passes through bit-exact with no width change.

## Timing
- Reset values:
  - `cnt = 0`, `wr_ptr = 0`, `rd_ptr = 0`, `beat = 0`.
  - `vld_out = 0`, `rdy_in = 1`.
  - `dout_* = 0`, `ovf = 0`, `drop_cnt = 0`.
  - Slot storage resets to 0.
- Latency: a frame accepted at edge t shows beat 0 on `vld_out` in the cycle after t, when `cnt` was 0.
- Throughput: one bin per cycle with `rdy_out` held high, so the sustained input rate is one frame per 8 cycles. Back-to-back frames stream with no bubble between beat 7 and the next beat 0.
- Burst absorption: two frames arriving in consecutive cycles are both accepted when `cnt` was 0. A third frame is dropped unless it coincides with `pop_last`.
- `rdy_in` is combinational from `cnt` and does not include `pop_last`. `rdy_in = 0` with a successful accept is therefore legal.
- `ovf` is combinational in the drop cycle. `drop_cnt` updates at the following edge.
- Reset asserted mid-frame:
  - Immediately clears all state.
  - Buffered frames are lost.
  - No partial frame is emitted after release.
- `brev` changes between frames take effect per frame. A frame in flight keeps the order sampled at its accept.

## Test plan
- Single natural-order frame:
  - Stimulus: after reset, `din_re` lane k = k+1 and `din_im` lane k = -(k+1), `brev = 0`, `rdy_out = 1`.
  - Required: 8 consecutive beats, with `dout_idx` 0..7, `dout_re` 1..8, `dout_im` -1..-8, and `dout_last` only on idx 7.
- Bit-reversed frame:
  - Stimulus: same data with `brev = 1`.
  - Required: `dout_idx` sequence 0,4,2,6,1,5,3,7, with `dout_re` = idx+1 on every beat.
- Backpressure:
  - Stimulus: `rdy_out` low for 5 cycles mid-frame at beat 3.
  - Required: `dout_*` stay at idx 3 and hold stable; the frame then resumes at beat 4, for 8 beats total.
- Overflow:
  - Stimulus: `rdy_out = 0`, then 3 frames on consecutive cycles.
  - Required: `cnt` reaches 2, `rdy_in` goes 0, the third frame pulses `ovf`, and `drop_cnt = 1`. With `rdy_out = 1`, the output is exactly frames 1 and 2 (16 beats).
- Coincident accept and pop:
  - Stimulus: `cnt = 2`, then `vld_in` asserted in the cycle of `pop_last`.
  - Required: the frame is accepted, there is no `ovf`, `cnt` stays 2, and all 3 frames are emitted in order.
- Reset mid-frame and saturation:
  - Stimulus: assert `rst_n` low at beat 4.
  - Required: next cycle `vld_out = 0`, `rdy_in = 1` and `dout_re = 0`. After 260 drops, `drop_cnt = 255`.
